// File: rtl/mempool_cc_tcdm_shim.sv
// Elastic shim between the Snitch data port and the TCDM interconnect:
// request FIFO, outstanding-credit limiter, response buffer and status.

module mempool_cc_tcdm_shim_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    output logic [Width-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready
);
    localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [IdxWidth-1:0] wr_idx_q, rd_idx_q;
    logic                wr_wrap_q, rd_wrap_q;
    logic [Width-1:0]    mem_q [Depth];
    logic                same_idx, empty, full, push, pop;

    // Equal indices mean empty when wrap bits agree and full when they differ.
    assign same_idx   = (wr_idx_q == rd_idx_q);
    assign empty      = same_idx && (wr_wrap_q == rd_wrap_q);
    assign full       = same_idx && (wr_wrap_q != rd_wrap_q);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign pop_data   = mem_q[rd_idx_q];
    assign push       = push_valid && !full;
    assign pop        = pop_ready && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q  <= '0;
            wr_wrap_q <= 1'b0;
            rd_idx_q  <= '0;
            rd_wrap_q <= 1'b0;
        end else begin
            if (push) begin
                if (wr_idx_q == IdxWidth'(Depth - 1)) begin
                    wr_idx_q  <= '0;
                    wr_wrap_q <= !wr_wrap_q;
                end else begin
                    wr_idx_q <= wr_idx_q + IdxWidth'(1);
                end
            end
            if (pop) begin
                if (rd_idx_q == IdxWidth'(Depth - 1)) begin
                    rd_idx_q  <= '0;
                    rd_wrap_q <= !rd_wrap_q;
                end else begin
                    rd_idx_q <= rd_idx_q + IdxWidth'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_idx_q] <= push_data;
        end
    end
endmodule

module mempool_cc_tcdm_shim #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned RegisterResp   = 1,
    parameter int unsigned ErrCntWidth    = 8,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned OutWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [AddrWidth-1:0]   core_qaddr_i,
    input  logic                   core_qwrite_i,
    input  logic [3:0]             core_qamo_i,
    input  logic [DataWidth-1:0]   core_qdata_i,
    input  logic [StrbWidth-1:0]   core_qstrb_i,
    input  logic [IdWidth-1:0]     core_qid_i,
    input  logic                   core_qvalid_i,
    output logic                   core_qready_o,
    output logic [DataWidth-1:0]   core_pdata_o,
    output logic                   core_perror_o,
    output logic [IdWidth-1:0]     core_pid_o,
    output logic                   core_pvalid_o,
    input  logic                   core_pready_i,
    output logic [AddrWidth-1:0]   tcdm_qaddr_o,
    output logic                   tcdm_qwrite_o,
    output logic [3:0]             tcdm_qamo_o,
    output logic [DataWidth-1:0]   tcdm_qdata_o,
    output logic [StrbWidth-1:0]   tcdm_qstrb_o,
    output logic [IdWidth-1:0]     tcdm_qid_o,
    output logic                   tcdm_qvalid_o,
    input  logic                   tcdm_qready_i,
    input  logic [DataWidth-1:0]   tcdm_pdata_i,
    input  logic                   tcdm_perror_i,
    input  logic [IdWidth-1:0]     tcdm_pid_i,
    input  logic                   tcdm_pvalid_i,
    output logic                   tcdm_pready_o,
    output logic [OutWidth-1:0]    outstanding_o,
    output logic                   idle_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);
    localparam int unsigned ReqWidth  = AddrWidth + 1 + 4 + DataWidth + StrbWidth + IdWidth;
    localparam int unsigned RespWidth = DataWidth + 1 + IdWidth;

    logic [ReqWidth-1:0]    req_in, req_out;
    logic [RespWidth-1:0]   resp_in, resp_out;
    logic                   req_valid, req_empty, credit_ok, q_fire, p_fire;
    logic [OutWidth-1:0]    outstanding_q;
    logic [ErrCntWidth-1:0] err_cnt_q;

    assign req_in  = {core_qaddr_i, core_qwrite_i, core_qamo_i, core_qdata_i, core_qstrb_i, core_qid_i};
    assign {tcdm_qaddr_o, tcdm_qwrite_o, tcdm_qamo_o, tcdm_qdata_o, tcdm_qstrb_o, tcdm_qid_o} = req_out;
    assign resp_in = {tcdm_pdata_i, tcdm_perror_i, tcdm_pid_i};
    assign {core_pdata_o, core_perror_o, core_pid_o} = resp_out;

    assign credit_ok     = (outstanding_q < OutWidth'(MaxOutstanding));
    assign tcdm_qvalid_o = req_valid && credit_ok;

    if (ReqDepth == 0) begin : g_req_pass
        assign req_out       = req_in;
        assign req_valid     = core_qvalid_i;
        assign core_qready_o = tcdm_qready_i && credit_ok;
        assign req_empty     = 1'b1;
    end else begin : g_req_fifo
        mempool_cc_tcdm_shim_fifo #(
            .Width (ReqWidth),
            .Depth (ReqDepth)
        ) i_req_fifo (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .push_data  (req_in),
            .push_valid (core_qvalid_i),
            .push_ready (core_qready_o),
            .pop_data   (req_out),
            .pop_valid  (req_valid),
            .pop_ready  (tcdm_qready_i && credit_ok)
        );
        assign req_empty = !req_valid;
    end

    if (RegisterResp == 0) begin : g_resp_pass
        assign resp_out      = resp_in;
        assign core_pvalid_o = tcdm_pvalid_i;
        assign tcdm_pready_o = core_pready_i;
    end else begin : g_resp_fifo
        mempool_cc_tcdm_shim_fifo #(
            .Width (RespWidth),
            .Depth (MaxOutstanding)
        ) i_resp_fifo (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .push_data  (resp_in),
            .push_valid (tcdm_pvalid_i),
            .push_ready (tcdm_pready_o),
            .pop_data   (resp_out),
            .pop_valid  (core_pvalid_o),
            .pop_ready  (core_pready_i)
        );

        // The credit limit guarantees a free slot for every response in flight.
        resp_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(tcdm_pvalid_i && !tcdm_pready_o));
    end

    assign q_fire = tcdm_qvalid_o && tcdm_qready_i;
    assign p_fire = core_pvalid_o && core_pready_i;

    // A credit is held from issue until the response has left toward the core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (q_fire && !p_fire) begin
            outstanding_q <= outstanding_q + OutWidth'(1);
        end else if (!q_fire && p_fire && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - OutWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (p_fire && core_perror_o && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
        end
    end

    assign outstanding_o = outstanding_q;
    assign err_cnt_o     = err_cnt_q;
    assign idle_o        = req_empty && (outstanding_q == '0);
endmodule

// File: tb/tb_mempool_cc_tcdm_shim.sv
// Scoreboard bench for mempool_cc_tcdm_shim: a TCDM responder model,
// request/response monitors against expected queues, directed scenarios.

module tb_mempool_cc_tcdm_shim;
    typedef struct {
        logic [31:0] addr;
        logic [4:0]  id;
    } req_t;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk, rst_n;
    logic [31:0] core_qaddr, core_qdata, core_pdata, tcdm_qaddr, tcdm_qdata, tcdm_pdata;
    logic        core_qwrite, core_qvalid, core_qready, core_perror, core_pvalid, core_pready;
    logic [3:0]  core_qamo, core_qstrb, tcdm_qamo, tcdm_qstrb;
    logic [4:0]  core_qid, core_pid, tcdm_qid, tcdm_pid;
    logic        tcdm_qwrite, tcdm_qvalid, tcdm_qready, tcdm_perror, tcdm_pvalid, tcdm_pready;
    logic [2:0]  outstanding;
    logic        idle;
    logic [1:0]  err_cnt;

    int    checks = 0;
    int    errors = 0;
    int    issued_cnt = 0;
    bit    resp_en = 0;
    req_t  exp_req[$];
    resp_t exp_resp[$];
    req_t  pend[$];

    mempool_cc_tcdm_shim #(
        .ErrCntWidth (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_qaddr_i  (core_qaddr),
        .core_qwrite_i (core_qwrite),
        .core_qamo_i   (core_qamo),
        .core_qdata_i  (core_qdata),
        .core_qstrb_i  (core_qstrb),
        .core_qid_i    (core_qid),
        .core_qvalid_i (core_qvalid),
        .core_qready_o (core_qready),
        .core_pdata_o  (core_pdata),
        .core_perror_o (core_perror),
        .core_pid_o    (core_pid),
        .core_pvalid_o (core_pvalid),
        .core_pready_i (core_pready),
        .tcdm_qaddr_o  (tcdm_qaddr),
        .tcdm_qwrite_o (tcdm_qwrite),
        .tcdm_qamo_o   (tcdm_qamo),
        .tcdm_qdata_o  (tcdm_qdata),
        .tcdm_qstrb_o  (tcdm_qstrb),
        .tcdm_qid_o    (tcdm_qid),
        .tcdm_qvalid_o (tcdm_qvalid),
        .tcdm_qready_i (tcdm_qready),
        .tcdm_pdata_i  (tcdm_pdata),
        .tcdm_perror_i (tcdm_perror),
        .tcdm_pid_i    (tcdm_pid),
        .tcdm_pvalid_i (tcdm_pvalid),
        .tcdm_pready_o (tcdm_pready),
        .outstanding_o (outstanding),
        .idle_o        (idle),
        .err_cnt_o     (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // TCDM model: answers each issued request one or more cycles later, in order.
    initial begin
        tcdm_pvalid = 1'b0;
        tcdm_pdata  = '0;
        tcdm_perror = 1'b0;
        tcdm_pid    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
            end else begin
                if (tcdm_pvalid && tcdm_pready) void'(pend.pop_front());
                if (tcdm_qvalid && tcdm_qready) pend.push_back('{tcdm_qaddr, tcdm_qid});
            end
            @(posedge clk);
            #1;
            if (resp_en && pend.size() > 0) begin
                tcdm_pvalid = 1'b1;
                tcdm_pdata  = 32'hDEAD_0000 + pend[0].addr;
                tcdm_perror = pend[0].addr[8];
                tcdm_pid    = pend[0].id;
            end else begin
                tcdm_pvalid = 1'b0;
            end
        end
    end

    // Request monitor: issued requests must match accepted ones, in order.
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_req.delete();
            end else if (tcdm_qvalid && tcdm_qready) begin
                issued_cnt++;
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 32'(tcdm_qid), 32'hFFFF_FFFF);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_id", 32'(tcdm_qid), 32'(e.id));
                    chk("req_addr", tcdm_qaddr, e.addr);
                    chk("req_data", tcdm_qdata, ~e.addr);
                    chk("req_attr", 32'({tcdm_qwrite, tcdm_qamo, tcdm_qstrb}), 32'h00F);
                end
            end
        end
    end

    // Response monitor: delivered responses and the saturating error count.
    initial begin
        resp_t e;
        int    err_model = 0;
        bit    err_pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_resp.delete();
                err_model = 0;
                err_pend  = 0;
            end else begin
                if (err_pend) begin
                    chk("err_cnt", 32'(err_cnt), 32'(err_model));
                    err_pend = 0;
                end
                if (core_pvalid && core_pready) begin
                    if (exp_resp.size() == 0) begin
                        chk("resp_unexpected", 32'(core_pid), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_resp.pop_front();
                        chk("resp_id", 32'(core_pid), 32'(e.id));
                        chk("resp_data", core_pdata, e.data);
                        chk("resp_err", 32'(core_perror), 32'(e.err));
                        if (e.err && err_model < 3) err_model++;
                        err_pend = 1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [4:0] id);
        bit ok = 0;
        core_qvalid = 1'b1;
        core_qaddr  = a;
        core_qdata  = ~a;
        core_qid    = id;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (core_qready) begin
                ok = 1;
                exp_req.push_back('{a, id});
                exp_resp.push_back('{id, 32'hDEAD_0000 + a, a[8]});
            end
            @(posedge clk);
            #1;
        end
        core_qvalid = 1'b0;
        if (!ok) chk("send_timeout", 32'(id), 32'hFFFF_FFFF);
    endtask

    task automatic drain(input string name);
        bit done = 0;
        resp_en     = 1;
        core_pready = 1'b1;
        tcdm_qready = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (idle && exp_resp.size() == 0 && exp_req.size() == 0) done = 1;
        end
        chk(name, 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t_p, t_q, bad;
        bit  seen;
        rst_n       = 1'b0;
        core_qaddr  = '0;
        core_qwrite = 1'b0;
        core_qamo   = '0;
        core_qdata  = '0;
        core_qstrb  = 4'hF;
        core_qid    = '0;
        core_qvalid = 1'b0;
        core_pready = 1'b0;
        tcdm_qready = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_core_qready", 32'(core_qready), 32'd1);
        chk("rst_tcdm_qvalid", 32'(tcdm_qvalid), 32'd0);
        chk("rst_core_pvalid", 32'(core_pvalid), 32'd0);
        chk("rst_tcdm_pready", 32'(tcdm_pready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // FIFO full with the interconnect stalled, then ordered release
        tcdm_qready = 1'b0;
        resp_en     = 0;
        send(32'h10, 5'h01);
        send(32'h14, 5'h02);
        core_qvalid = 1'b1;
        core_qaddr  = 32'h18;
        core_qdata  = ~32'h18;
        core_qid    = 5'h03;
        @(negedge clk);
        chk("t3_qready_full", 32'(core_qready), 32'd0);
        chk("t3_head_id", 32'(tcdm_qid), 32'h01);
        @(posedge clk);
        #1;
        tcdm_qready = 1'b1;
        send(32'h18, 5'h03);
        drain("t3_drain");

        // Credit limit: six loads, no responses
        issued_cnt  = 0;
        resp_en     = 0;
        core_pready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'h20 + 32'(4 * i), 5'(i + 4));
        cycles(3);
        @(negedge clk);
        chk("t2_outstanding", 32'(outstanding), 32'd4);
        chk("t2_issued", 32'(issued_cnt), 32'd4);
        chk("t2_qvalid_gated", 32'(tcdm_qvalid), 32'd0);
        @(posedge clk);
        #1;
        resp_en     = 1;
        core_pready = 1'b1;
        t_p = -1;
        t_q = -1;
        for (int n = 0; n < 50 && t_q < 0; n++) begin
            @(negedge clk);
            if (t_p < 0 && core_pvalid && core_pready) t_p = n;
            if (t_q < 0 && tcdm_qvalid && tcdm_qready) t_q = n;
        end
        chk("t2_first_resp_seen", 32'(t_p >= 0), 32'd1);
        chk("t2_fifth_issue_delay", 32'(t_q - t_p), 32'd1);
        @(posedge clk);
        #1;
        drain("t2_drain");

        // Simultaneous issue and delivery at outstanding 2
        resp_en     = 0;
        core_pready = 1'b0;
        send(32'h30, 5'h08);
        send(32'h34, 5'h09);
        cycles(2);
        tcdm_qready = 1'b0;
        send(32'h38, 5'h0A);
        resp_en = 1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = core_pvalid;
        end
        chk("t4_pvalid_seen", 32'(seen), 32'd1);
        chk("t4_out_before", 32'(outstanding), 32'd2);
        @(posedge clk);
        #1;
        tcdm_qready = 1'b1;
        core_pready = 1'b1;
        @(negedge clk);
        chk("t4_both_fire", 32'({tcdm_qvalid && tcdm_qready, core_pvalid && core_pready}), 32'h3);
        @(posedge clk);
        #1;
        core_pready = 1'b0;
        @(negedge clk);
        chk("t4_out_after", 32'(outstanding), 32'd2);
        @(posedge clk);
        #1;
        drain("t4_drain");

        // Response backpressure: four responses parked, none refused
        resp_en     = 1;
        core_pready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(i), 5'(16 + i));
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (tcdm_pvalid && !tcdm_pready) bad++;
        end
        chk("t5_refused", 32'(bad), 32'd0);
        chk("t5_outstanding", 32'(outstanding), 32'd4);
        chk("t5_head_id", 32'(core_pid), 32'd16);
        chk("t5_head_data", core_pdata, 32'hDEAD_0000);
        @(posedge clk);
        #1;
        drain("t5_drain");

        // Saturating error counter: five errors, then a clean response
        for (int i = 0; i < 5; i++) send(32'h100 + 32'(4 * i), 5'(20 + i));
        send(32'h40, 5'd25);
        drain("t6_drain");
        @(negedge clk);
        chk("t6_err_final", 32'(err_cnt), 32'd3);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of traffic
        resp_en = 0;
        send(32'h50, 5'd26);
        send(32'h54, 5'd27);
        send(32'h58, 5'd28);
        chk("t1_out_pre", 32'(outstanding), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t1_outstanding", 32'(outstanding), 32'd0);
        chk("t1_idle", 32'(idle), 32'd1);
        chk("t1_tcdm_qvalid", 32'(tcdm_qvalid), 32'd0);
        chk("t1_core_pvalid", 32'(core_pvalid), 32'd0);
        exp_req.delete();
        exp_resp.delete();
        cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_idle_after", 32'(idle), 32'd1);
        chk("t1_err_cleared", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
